// File: rtl/xvga_timing.sv
// Raster timing generator: pixel/line counters with registered sync, blank and frame pulse.
// Define XVGA_FRAME_COUNT_EN to enable the 16-bit completed-frame counter on frame_count.
module xvga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic        h_wrap;
    logic        v_wrap;
    logic        frame_wrap;
    logic [10:0] h_next;
    logic [9:0]  v_next;

    // Decode is done on the next position so the sync/blank flops line up with the counters.
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        v_wrap     = (vcount == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vcount + 10'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcount      <= 11'd0;
            vcount      <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce && frame_wrap;
            if (ce) begin
                hcount <= h_next;
                vcount <= v_next;
                hsync  <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
                vsync  <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
                blank  <= (h_next >= H_ACT) || (v_next >= V_ACT);
            end
        end
    end

`ifdef XVGA_FRAME_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 16'd0;
        end else if (ce && frame_wrap) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: a default-timing instance plus a reduced-timing instance for frame wraps.
module tb_xvga_timing;

    logic clock;
    logic reset_n;
    logic ce;

    logic [10:0] hc  [2];
    logic [9:0]  vc  [2];
    logic        hs  [2];
    logic        vs  [2];
    logic        bl  [2];
    logic        fs  [2];
    logic [15:0] fc  [2];

    int errors = 0;
    int checks = 0;

    // Timing parameters of each instance: 0 = default XVGA, 1 = reduced raster.
    int p_ha [2] = '{1024, 20};
    int p_hf [2] = '{24, 3};
    int p_hs [2] = '{136, 5};
    int p_hb [2] = '{160, 4};
    int p_va [2] = '{768, 12};
    int p_vf [2] = '{3, 2};
    int p_vs [2] = '{6, 3};
    int p_vb [2] = '{29, 3};

    // Reference position and frame state.
    int m_h  [2];
    int m_v  [2];
    int m_fs [2];
    int m_fc [2];

    xvga_timing u_big (
        .clock       (clock),
        .reset_n     (reset_n),
        .ce          (ce),
        .hcount      (hc[0]),
        .vcount      (vc[0]),
        .hsync       (hs[0]),
        .vsync       (vs[0]),
        .blank       (bl[0]),
        .frame_start (fs[0]),
        .frame_count (fc[0])
    );

    xvga_timing #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3)
    ) u_small (
        .clock       (clock),
        .reset_n     (reset_n),
        .ce          (ce),
        .hcount      (hc[1]),
        .vcount      (vc[1]),
        .hsync       (hs[1]),
        .vsync       (vs[1]),
        .blank       (bl[1]),
        .frame_start (fs[1]),
        .frame_count (fc[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int h_total(input int i);
        return p_ha[i] + p_hf[i] + p_hs[i] + p_hb[i];
    endfunction

    function automatic int v_total(input int i);
        return p_va[i] + p_vf[i] + p_vs[i] + p_vb[i];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_h[i]  = 0;
                m_v[i]  = 0;
                m_fs[i] = 0;
                m_fc[i] = 0;
            end else begin
                m_fs[i] = 0;
                if (ce) begin
                    m_h[i] = m_h[i] + 1;
                    if (m_h[i] == h_total(i)) begin
                        m_h[i] = 0;
                        m_v[i] = m_v[i] + 1;
                        if (m_v[i] == v_total(i)) begin
                            m_v[i]  = 0;
                            m_fs[i] = 1;
                            m_fc[i] = (m_fc[i] + 1) % 65536;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input int i);
        int hsw_lo;
        int vsw_lo;
        int exp_fc;
        hsw_lo = p_ha[i] + p_hf[i];
        vsw_lo = p_va[i] + p_vf[i];
`ifdef XVGA_FRAME_COUNT_EN
        exp_fc = m_fc[i];
`else
        exp_fc = 0;
`endif
        check($sformatf("u%0d.hcount", i), 32'(hc[i]), 32'(m_h[i]));
        check($sformatf("u%0d.vcount", i), 32'(vc[i]), 32'(m_v[i]));
        check($sformatf("u%0d.hsync", i), 32'(hs[i]),
              32'(!(m_h[i] >= hsw_lo && m_h[i] < hsw_lo + p_hs[i])));
        check($sformatf("u%0d.vsync", i), 32'(vs[i]),
              32'(!(m_v[i] >= vsw_lo && m_v[i] < vsw_lo + p_vs[i])));
        check($sformatf("u%0d.blank", i), 32'(bl[i]),
              32'(m_h[i] >= p_ha[i] || m_v[i] >= p_va[i]));
        check($sformatf("u%0d.frame_start", i), 32'(fs[i]), 32'(m_fs[i]));
        check($sformatf("u%0d.frame_count", i), 32'(fc[i]), 32'(exp_fc));
    endtask

    task automatic check_all();
        check_model(0);
        check_model(1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            check_all();
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int low_cnt;
        reset_n = 1'b0;
        ce      = 1'b0;
        #12;
        check_all();
        check("rst.hsync", 32'(hs[0]), 32'd1);
        check("rst.blank", 32'(bl[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Mid-line reset at hcount=500 must take effect before the next edge.
        ce = 1'b1;
        step(500);
        check("pre_rst.hcount", 32'(hc[0]), 32'd500);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("async_rst.hcount", 32'(hc[0]), 32'd0);
        check("async_rst.vcount", 32'(vc[0]), 32'd0);
        check("async_rst.hsync", 32'(hs[0]), 32'd1);
        check("async_rst.vsync", 32'(vs[0]), 32'd1);
        check("async_rst.blank", 32'(bl[0]), 32'd0);
        check("async_rst.fs", 32'(fs[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Release: first advancing clock gives hcount=1, and no frame_start.
        step(1);
        check("release.hcount", 32'(hc[0]), 32'd1);
        check("release.fs", 32'(fs[0]), 32'd0);

        step(1342);
        check("line_end.hcount", 32'(hc[0]), 32'd1343);
        check("line_end.vcount", 32'(vc[0]), 32'd0);
        check("line_end.blank", 32'(bl[0]), 32'd1);
        step(1);
        check("line_wrap.hcount", 32'(hc[0]), 32'd0);
        check("line_wrap.vcount", 32'(vc[0]), 32'd1);
        check("line_wrap.blank", 32'(bl[0]), 32'd0);

        // Stall just before the hsync window.
        step(1047);
        check("stall_pre.hcount", 32'(hc[0]), 32'd1047);
        ce = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("stall.hcount", 32'(hc[0]), 32'd1047);
            check("stall.hsync", 32'(hs[0]), 32'd1);
        end
        ce = 1'b1;
        step(1);
        check("resume.hcount", 32'(hc[0]), 32'd1048);
        check("resume.hsync", 32'(hs[0]), 32'd0);

        low_cnt = 0;
        for (int k = 0; k < 1344; k++) begin
            step(1);
            if (hs[0] == 1'b0) low_cnt++;
        end
        check("hsync_width", 32'(low_cnt), 32'd136);

        // Frame wrap on the reduced raster: 32 x 20 = 640 advances.
        apply_reset();
        step(640);
        check("frame.hcount", 32'(hc[1]), 32'd0);
        check("frame.vcount", 32'(vc[1]), 32'd0);
        check("frame.fs", 32'(fs[1]), 32'd1);
`ifdef XVGA_FRAME_COUNT_EN
        check("frame.fc", 32'(fc[1]), 32'd1);
`else
        check("frame.fc", 32'(fc[1]), 32'd0);
`endif
        ce = 1'b0;
        step(3);
        check("frame_hold.fs", 32'(fs[1]), 32'd0);
        check("frame_hold.hcount", 32'(hc[1]), 32'd0);
        ce = 1'b1;

        low_cnt = 0;
        for (int k = 0; k < 640; k++) begin
            step(1);
            if (vs[1] == 1'b0) low_cnt++;
        end
        check("vsync_width", 32'(low_cnt), 32'd96);

        // Randomized enable pattern, with an occasional asynchronous reset.
        for (int k = 0; k < 4000; k++) begin
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1999) == 0) begin
                apply_reset();
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xvga_timing.md
XVGA_TIMING -- requirements
Module: xvga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 136, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 3, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 6, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 29, vertical back porch in lines.
REQ-009 SHALL have port clock, input, 1 bit: pixel clock; one clock and reset only, reset asynchronous and active-low.
REQ-010 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-011 SHALL have port ce, input, 1 bit: pixel advance enable.
REQ-012 SHALL have port hcount, output, 11 bits: current pixel column.
REQ-013 SHALL have port vcount, output, 10 bits: current line.
REQ-014 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-015 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-016 SHALL have port blank, output, 1 bit: high outside active area.
REQ-017 SHALL have port frame_start, output, 1 bit: one-clock pulse at frame wrap.
REQ-018 SHALL have port frame_count, output, 16 bits: completed-frame count (see Configuration).

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
REQ-020 SHALL register every output; no combinational path from any input to any output.
REQ-021 SHALL, on a rising clock with ce=1, increment hcount; at hcount=H_TOTAL-1 wrap it to 0 and increment vcount.
REQ-022 SHALL, when hcount wraps with vcount=V_TOTAL-1, wrap vcount to 0.
REQ-023 SHALL hold all counters and hsync/vsync/blank unchanged on clocks with ce=0.
REQ-024 SHALL drive hsync=0 exactly while hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (1048..1183), else 1.
REQ-025 SHALL drive vsync=0 exactly while vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (771..776), else 1.
REQ-026 SHALL drive blank=1 exactly when hcount>=H_ACTIVE or vcount>=V_ACTIVE.
REQ-027 SHALL keep hsync, vsync, blank aligned with the hcount/vcount values presented in the same cycle (zero relative latency).
REQ-028 SHALL assert frame_start for exactly one clock, the cycle in which hcount=0, vcount=0 are first presented after a wrap from (H_TOTAL-1, V_TOTAL-1); low otherwise, including while ce=0 holds (0,0).
REQ-029 SHALL keep hcount/vcount values never exceeding H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-030 SHALL, while reset_n=0, force hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, frame_count=0, independent of clock.
REQ-031 SHALL, on reset_n assertion mid-frame, abandon the frame immediately; first advancing clock after release yields hcount=1, vcount=0.
REQ-032 SHALL NOT assert frame_start as a result of reset release.

Configuration
REQ-033 SHALL, with macro XVGA_FRAME_COUNT_EN defined, increment frame_count by 1 (mod 2^16) in the same cycle frame_start asserts.
REQ-034 SHALL, without XVGA_FRAME_COUNT_EN, tie frame_count to 0 and instantiate no counter register for it.

Verification
REQ-035 SHALL cover reset: reset_n=0 mid-line at hcount=500 -> hcount=0, vcount=0, hsync=1, vsync=1, blank=0 before next clock edge.
REQ-036 SHALL cover line wrap: ce=1, 1343 clocks from reset -> hcount=1343, vcount=0, blank=1; next clock -> hcount=0, vcount=1, blank=0.
REQ-037 SHALL cover sync windows: hsync=0 exactly for hcount 1048..1183 (136 cycles/line); vsync=0 exactly for vcount 771..776.
REQ-038 SHALL cover frame wrap: 1,083,264 ce clocks after reset -> hcount=0, vcount=0, frame_start=1 for one clock; frame_count=1 with XVGA_FRAME_COUNT_EN, 0 without.
REQ-039 SHALL cover stall: ce=0 for 10 clocks at hcount=1047 -> all outputs frozen, hsync=1; ce=1 -> hcount=1048, hsync=0.
